// File: rtl/blk_ctrl_responder.sv
// Block-side control endpoint: accepts core cmd, sequences enable/flush,
// tracks in-flight ops so a flush completes only once the block drains.
module blk_ctrl_responder #(
    parameter int INFL_W   = 3,
    parameter int FLUSH_TO = 15,
    parameter int EPOCH_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_op,
    output logic               cmd_ready,
    output logic               st_ack,
    output logic               st_err,
    output logic [2:0]         st_state,
    output logic               st_busy,
    output logic               st_timeout,
    output logic [EPOCH_W-1:0] st_epoch,
    output logic               blk_en,
    output logic               blk_flush,
    input  logic               op_issue,
    input  logic               op_retire
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STALL = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_START  = 3'd1;
    localparam logic [2:0] OP_STALL  = 3'd2;
    localparam logic [2:0] OP_RESUME = 3'd3;
    localparam logic [2:0] OP_FLUSH  = 3'd4;
    localparam logic [2:0] OP_KILL   = 3'd5;

    localparam logic [INFL_W-1:0]  INFL_MAX  = '1;
    localparam logic [INFL_W-1:0]  INFL_ONE  = 1;
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = 1;
    localparam logic [7:0]         TO_LAST   = 8'(FLUSH_TO - 1);

    logic [2:0]         r_state;
    logic [INFL_W-1:0]  r_infl;
    logic [7:0]         r_timer;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_timeout;
    logic               r_ack;
    logic               r_err;

    logic               w_accept;
    logic               w_issue;
    logic               w_inc;
    logic               w_dec;
    logic               w_clamp;
    logic [INFL_W-1:0]  w_infl_upd;
    logic               w_legal;
    logic [2:0]         w_nxt;

    assign cmd_ready  = (r_state != S_FLUSH);
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_issue    = op_issue & (r_state == S_RUN);
    assign w_inc      = w_issue & ~op_retire;
    assign w_dec      = op_retire & ~w_issue;

    // In-flight update with saturation; a clamped step is a protocol violation.
    always_comb begin
        w_infl_upd = r_infl;
        w_clamp    = 1'b0;
        if (w_inc) begin
            if (r_infl == INFL_MAX) w_clamp = 1'b1;
            else w_infl_upd = r_infl + INFL_ONE;
        end else if (w_dec) begin
            if (r_infl == '0) w_clamp = 1'b1;
            else w_infl_upd = r_infl - INFL_ONE;
        end
    end

    // Command legality and target state for the current state.
    always_comb begin
        w_legal = 1'b0;
        w_nxt   = r_state;
        case (cmd_op)
            OP_NOP: w_legal = 1'b1;
            OP_START: begin
                if (r_state == S_IDLE || r_state == S_DONE) begin
                    w_legal = 1'b1;
                    w_nxt   = S_RUN;
                end
            end
            OP_STALL: begin
                if (r_state == S_RUN || r_state == S_STALL) begin
                    w_legal = 1'b1;
                    w_nxt   = S_STALL;
                end
            end
            OP_RESUME: begin
                if (r_state == S_STALL) begin
                    w_legal = 1'b1;
                    w_nxt   = S_RUN;
                end
            end
            OP_FLUSH: begin
                w_legal = 1'b1;
                w_nxt   = S_FLUSH;
            end
            OP_KILL: begin
                w_legal = 1'b1;
                w_nxt   = S_IDLE;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // State, counters, flush sequencing and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_infl    <= '0;
            r_timer   <= '0;
            r_epoch   <= '0;
            r_timeout <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ack  <= w_accept;
            r_err  <= w_clamp | (w_accept & ~w_legal);
            r_infl <= w_infl_upd;
            if (r_state == S_FLUSH) begin
                if (w_infl_upd == '0) begin
                    r_state <= S_DONE;
                    r_epoch <= r_epoch + EPOCH_ONE;
                end else if (r_timer == TO_LAST) begin
                    r_state   <= S_DONE;
                    r_epoch   <= r_epoch + EPOCH_ONE;
                    r_timeout <= 1'b1;
                    r_infl    <= '0;
                end else begin
                    r_timer <= r_timer + 8'd1;
                end
            end else if (w_accept & w_legal) begin
                r_state <= w_nxt;
                if (cmd_op == OP_START) r_timeout <= 1'b0;
                if (cmd_op == OP_FLUSH) r_timer <= '0;
                if (cmd_op == OP_KILL) begin
                    r_infl  <= '0;
                    r_epoch <= r_epoch + EPOCH_ONE;
                end
            end
        end
    end

    assign st_ack     = r_ack;
    assign st_err     = r_err;
    assign st_state   = r_state;
    assign st_busy    = (r_infl != '0);
    assign st_timeout = r_timeout;
    assign st_epoch   = r_epoch;
    assign blk_en     = (r_state == S_RUN);
    assign blk_flush  = (r_state == S_FLUSH);

endmodule

// File: tb/tb_blk_ctrl_responder.sv
// Bench for blk_ctrl_responder: directed scenarios with constant
// expectations, then random traffic against a behavioural model.
module tb_blk_ctrl_responder;

    localparam int MAXI = 7;
    localparam int FTO  = 15;
    localparam int EMOD = 4;

    localparam logic [2:0] C_NOP    = 3'd0;
    localparam logic [2:0] C_START  = 3'd1;
    localparam logic [2:0] C_STALL  = 3'd2;
    localparam logic [2:0] C_RESUME = 3'd3;
    localparam logic [2:0] C_FLUSH  = 3'd4;
    localparam logic [2:0] C_KILL   = 3'd5;
    localparam logic [2:0] C_BAD    = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic       cmd_ready;
    logic       st_ack;
    logic       st_err;
    logic [2:0] st_state;
    logic       st_busy;
    logic       st_timeout;
    logic [1:0] st_epoch;
    logic       blk_en;
    logic       blk_flush;
    logic       op_issue;
    logic       op_retire;

    int checks = 0;
    int errors = 0;

    int m_state, m_infl, m_epoch, m_fcnt;
    bit m_to, m_ack, m_err;

    blk_ctrl_responder #(.INFL_W(3), .FLUSH_TO(15), .EPOCH_W(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .st_ack(st_ack), .st_err(st_err), .st_state(st_state),
        .st_busy(st_busy), .st_timeout(st_timeout), .st_epoch(st_epoch),
        .blk_en(blk_en), .blk_flush(blk_flush),
        .op_issue(op_issue), .op_retire(op_retire)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_infl = 0; m_epoch = 0; m_fcnt = 0;
        m_to = 0; m_ack = 0; m_err = 0;
    endtask

    // Spec-level model: integer occupancy, flush duration in cycles.
    task automatic model_clk(input bit v, input int op, input bit iss, input bit ret);
        int n;
        bit acc;
        bit ok;
        acc = v && (m_state != 3);
        n = m_infl + ((iss && m_state == 1) ? 1 : 0) - (ret ? 1 : 0);
        m_err = (n < 0) || (n > MAXI);
        if (n < 0) n = 0;
        if (n > MAXI) n = MAXI;
        m_ack = acc;
        ok = 1;
        if (m_state == 3) begin
            m_fcnt++;
            if (n == 0) begin
                m_state = 4; m_epoch = (m_epoch + 1) % EMOD;
            end else if (m_fcnt == FTO) begin
                m_state = 4; m_epoch = (m_epoch + 1) % EMOD;
                m_to = 1; n = 0;
            end
        end else if (acc) begin
            case (op)
                0: ok = 1;
                1: if (m_state == 0 || m_state == 4) begin m_state = 1; m_to = 0; end
                   else ok = 0;
                2: if (m_state == 1 || m_state == 2) m_state = 2; else ok = 0;
                3: if (m_state == 2) m_state = 1; else ok = 0;
                4: begin m_state = 3; m_fcnt = 0; end
                5: begin m_state = 0; n = 0; m_epoch = (m_epoch + 1) % EMOD; end
                default: ok = 0;
            endcase
            if (!ok) m_err = 1;
        end
        m_infl = n;
    endtask

    task automatic tick(input logic v, input logic [2:0] op, input logic iss, input logic ret);
        cmd_valid = v; cmd_op = op; op_issue = iss; op_retire = ret;
        @(posedge clk);
        if (rst) model_reset();
        else model_clk(v, int'(op), iss, ret);
        #1;
        cmd_valid = 1'b0; op_issue = 1'b0; op_retire = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(0, C_NOP, 0, 0);
        tick(0, C_NOP, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (st_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st_state); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", cmd_ready); end
        checks++; if (blk_en !== 1'b0) begin errors++; $display("FAIL reset_en got %0b exp 0", blk_en); end
        checks++; if (st_epoch !== 2'd0) begin errors++; $display("FAIL reset_epoch got %0d exp 0", st_epoch); end
        checks++; if ({st_ack, st_err, st_busy, st_timeout, blk_flush} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {st_ack, st_err, st_busy, st_timeout, blk_flush});
        end
    endtask

    task automatic test_start_stall_resume();
        logic [2:0] ops [3];
        logic [2:0] exp_st [3];
        logic       exp_en [3];
        ops    = '{C_START, C_STALL, C_RESUME};
        exp_st = '{3'd1, 3'd2, 3'd1};
        exp_en = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            tick(1, ops[i], 0, 0);
            checks++; if (st_ack !== 1'b1 || st_err !== 1'b0) begin
                errors++; $display("FAIL ssr_ack[%0d] got ack=%b err=%b exp ack=1 err=0", i, st_ack, st_err);
            end
            checks++; if (st_state !== exp_st[i] || blk_en !== exp_en[i]) begin
                errors++; $display("FAIL ssr_state[%0d] got st=%0d en=%b exp st=%0d en=%b", i, st_state, blk_en, exp_st[i], exp_en[i]);
            end
        end
    endtask

    task automatic test_flush_drain();
        int n;
        for (int i = 0; i < 3; i++) tick(0, C_NOP, 1, 0);
        checks++; if (st_busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %b exp 1", st_busy); end
        tick(1, C_FLUSH, 0, 0);
        checks++; if (st_state !== 3'd3 || cmd_ready !== 1'b0 || blk_flush !== 1'b1) begin
            errors++; $display("FAIL drain_enter got st=%0d rdy=%b fl=%b exp st=3 rdy=0 fl=1", st_state, cmd_ready, blk_flush);
        end
        n = 1;
        while (st_state === 3'd3 && n < 40) begin
            tick(0, C_NOP, 0, 1);
            if (st_state === 3'd3) n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL drain_len got %0d exp 3", n); end
        checks++; if (st_state !== 3'd4 || st_epoch !== 2'd1 || st_timeout !== 1'b0 || st_busy !== 1'b0) begin
            errors++; $display("FAIL drain_done got st=%0d ep=%0d to=%b busy=%b exp st=4 ep=1 to=0 busy=0", st_state, st_epoch, st_timeout, st_busy);
        end
    endtask

    task automatic test_flush_timeout();
        int n;
        tick(1, C_START, 0, 0);
        tick(0, C_NOP, 1, 0);
        tick(0, C_NOP, 1, 0);
        tick(1, C_FLUSH, 0, 0);
        n = 1;
        while (st_state === 3'd3 && n < 60) begin
            tick(0, C_NOP, 0, 0);
            if (st_state === 3'd3) n++;
        end
        checks++; if (n != 15) begin errors++; $display("FAIL to_len got %0d exp 15", n); end
        checks++; if (st_state !== 3'd4 || st_timeout !== 1'b1 || st_busy !== 1'b0 || st_epoch !== 2'd2) begin
            errors++; $display("FAIL to_done got st=%0d to=%b busy=%b ep=%0d exp st=4 to=1 busy=0 ep=2", st_state, st_timeout, st_busy, st_epoch);
        end
        tick(1, C_START, 0, 0);
        checks++; if (st_timeout !== 1'b0 || st_state !== 3'd1) begin
            errors++; $display("FAIL to_clear got to=%b st=%0d exp to=0 st=1", st_timeout, st_state);
        end
    endtask

    task automatic test_illegal();
        tick(1, C_KILL, 0, 0);
        tick(1, C_RESUME, 0, 0);
        checks++; if (st_ack !== 1'b1 || st_err !== 1'b1 || st_state !== 3'd0) begin
            errors++; $display("FAIL ill_resume got ack=%b err=%b st=%0d exp 1 1 0", st_ack, st_err, st_state);
        end
        tick(1, C_BAD, 0, 0);
        checks++; if (st_ack !== 1'b1 || st_err !== 1'b1 || st_state !== 3'd0) begin
            errors++; $display("FAIL ill_op7 got ack=%b err=%b st=%0d exp 1 1 0", st_ack, st_err, st_state);
        end
        tick(1, C_FLUSH, 0, 0);
        tick(1, C_START, 0, 0);
        checks++; if (st_ack !== 1'b0 || st_state !== 3'd4 || st_epoch !== 2'd0) begin
            errors++; $display("FAIL ill_inflush got ack=%b st=%0d ep=%0d exp ack=0 st=4 ep=0", st_ack, st_state, st_epoch);
        end
    endtask

    task automatic test_kill_wrap();
        logic [1:0] ep_exp;
        tick(1, C_START, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, C_NOP, 1, 0);
        tick(1, C_KILL, 0, 0);
        checks++; if (st_state !== 3'd0 || st_busy !== 1'b0 || st_epoch !== 2'd1) begin
            errors++; $display("FAIL kill got st=%0d busy=%b ep=%0d exp st=0 busy=0 ep=1", st_state, st_busy, st_epoch);
        end
        do_reset();
        ep_exp = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick(1, C_FLUSH, 0, 0);
            tick(0, C_NOP, 0, 0);
            ep_exp = ep_exp + 2'd1;
            checks++; if (st_epoch !== ep_exp || st_state !== 3'd4) begin
                errors++; $display("FAIL wrap[%0d] got ep=%0d st=%0d exp ep=%0d st=4", i, st_epoch, st_state, ep_exp);
            end
        end
    endtask

    task automatic test_saturate();
        tick(1, C_START, 0, 0);
        for (int i = 0; i < 7; i++) tick(0, C_NOP, 1, 0);
        tick(0, C_NOP, 1, 0);
        checks++; if (st_err !== 1'b1 || st_ack !== 1'b0) begin
            errors++; $display("FAIL sat_hi got err=%b ack=%b exp err=1 ack=0", st_err, st_ack);
        end
        tick(0, C_NOP, 1, 1);
        checks++; if (st_err !== 1'b0 || st_busy !== 1'b1) begin
            errors++; $display("FAIL sat_hold got err=%b busy=%b exp err=0 busy=1", st_err, st_busy);
        end
        tick(1, C_KILL, 0, 0);
        tick(0, C_NOP, 1, 0);
        checks++; if (st_busy !== 1'b0 || st_err !== 1'b0) begin
            errors++; $display("FAIL idle_issue got busy=%b err=%b exp 0 0", st_busy, st_err);
        end
        tick(0, C_NOP, 0, 1);
        checks++; if (st_err !== 1'b1 || st_ack !== 1'b0) begin
            errors++; $display("FAIL sat_lo got err=%b ack=%b exp err=1 ack=0", st_err, st_ack);
        end
    endtask

    task automatic test_reset_mid_flush();
        tick(1, C_START, 0, 0);
        tick(0, C_NOP, 1, 0);
        tick(0, C_NOP, 1, 0);
        tick(1, C_FLUSH, 0, 0);
        tick(0, C_NOP, 0, 0);
        rst = 1'b1;
        tick(0, C_NOP, 0, 0);
        rst = 1'b0;
        checks++; if (st_state !== 3'd0 || st_epoch !== 2'd0 || st_ack !== 1'b0 || st_busy !== 1'b0 || blk_flush !== 1'b0) begin
            errors++; $display("FAIL rst_flush got st=%0d ep=%0d ack=%b busy=%b fl=%b exp 0 0 0 0 0", st_state, st_epoch, st_ack, st_busy, blk_flush);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [8:0] got, exp;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            op = 3'($urandom_range(0, 7));
            if (op == C_KILL && $urandom_range(0, 3) != 0) op = C_NOP;
            rst = ($urandom_range(0, 199) == 0);
            tick(1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rst = 1'b0;
            got = {st_state, st_ack, st_err, st_busy, st_timeout, st_epoch};
            exp = {3'(m_state), m_ack, m_err, m_infl != 0, m_to, 2'(m_epoch)};
            checks++; if (got !== exp) begin
                errors++; $display("FAIL rnd_status[%0d] got %b exp %b", c, got, exp);
            end
            checks++; if ({cmd_ready, blk_en, blk_flush} !== {m_state != 3, m_state == 1, m_state == 3}) begin
                errors++; $display("FAIL rnd_ctrl[%0d] got %b exp %b", c, {cmd_ready, blk_en, blk_flush}, {m_state != 3, m_state == 1, m_state == 3});
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0;
        op_issue = 1'b0; op_retire = 1'b0;
        model_reset();
        test_reset();
        test_start_stall_resume();
        test_flush_drain();
        test_flush_timeout();
        test_illegal();
        test_kill_wrap();
        test_saturate();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
